// File: rtl/trace_pkg.sv
// Shared trace record layout and overflow-policy constants for the retire trace buffer.
package trace_pkg;

    localparam int TRACE_STALL = 0;
    localparam int TRACE_DROP  = 1;

    // Wide enough to hold an active count of up to four channels.
    localparam int CNT_W = 3;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        rdv;
        logic [4:0]  rd_x;
        logic [31:0] rd_data;
        logic        pcv;
        logic [31:0] pc_x;
        logic [31:0] seq;
        logic        gap;
    } trace_rec_t;

endpackage

// File: rtl/trace_compact.sv
// Packs the active retire channels: each channel gets its slot offset, plus the total active count.
module trace_compact
    import trace_pkg::*;
#(
    parameter int NCH = 2
) (
    input  logic [NCH-1:0]            active_i,
    output logic [NCH-1:0][CNT_W-1:0] offset_o,
    output logic [CNT_W-1:0]          count_o
);

    logic [CNT_W-1:0] acc;

    always_comb begin
        acc      = '0;
        offset_o = '0;
        for (int i = 0; i < NCH; i++) begin
            offset_o[i] = acc;
            acc         = acc + CNT_W'(active_i[i]);
        end
        count_o = acc;
    end

endmodule

// File: rtl/trace_buffer.sv
// Multi-channel retire trace FIFO with first-word fall-through output and a stall or drop overflow policy.
module trace_buffer
    import trace_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int DEPTH     = 16,
    parameter int DROP_MODE = TRACE_STALL
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NCH-1:0]          in_valid,
    input  logic [NCH-1:0][31:0]    in_pc,
    input  logic [NCH-1:0][31:0]    in_inst,
    input  logic [NCH-1:0]          in_rdv,
    input  logic [NCH-1:0][4:0]     in_rd_x,
    input  logic [NCH-1:0][31:0]    in_rd_data,
    input  logic [NCH-1:0]          in_pcv,
    input  logic [NCH-1:0][31:0]    in_pc_x,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output trace_rec_t              out_rec,
    output logic [$clog2(DEPTH):0]  level,
    output logic [15:0]             drop_cnt
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int SLOTS = 1 << AW;

    logic [NCH-1:0]            active;
    logic [NCH-1:0][CNT_W-1:0] offset;
    logic [CNT_W-1:0]          count;

    logic [AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]  level_q, level_d, free;
    logic [31:0]    seq_q, seq_d;
    logic [15:0]    drop_cnt_q, drop_cnt_d;
    logic           gap_q, gap_d;
    logic [16:0]    drop_sum;
    logic           accept, fits, push, drop, pop;

    trace_rec_t     wr_rec [NCH];
    logic [AW-1:0]  wr_idx [NCH];
    trace_rec_t     mem    [SLOTS];

    assign active = in_valid | in_rdv | in_pcv;

    trace_compact #(.NCH(NCH)) u_compact (
        .active_i (active),
        .offset_o (offset),
        .count_o  (count)
    );

    // Space is judged on the registered level only, so a pop this cycle never makes room this cycle.
    assign free   = LW'(DEPTH) - level_q;
    assign fits   = free >= LW'(count);
    assign accept = (DROP_MODE == TRACE_DROP) ? 1'b1 : (free >= LW'(NCH));
    assign push   = accept & fits & (count != '0);
    assign drop   = accept & ~fits;
    assign pop    = out_valid & out_ready;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            wr_idx[i] = wptr_q + AW'(offset[i]);
            wr_rec[i] = '{valid:   in_valid[i],
                          pc:      in_pc[i],
                          inst:    in_inst[i],
                          rdv:     in_rdv[i],
                          rd_x:    in_rd_x[i],
                          rd_data: in_rd_data[i],
                          pcv:     in_pcv[i],
                          pc_x:    in_pc_x[i],
                          seq:     seq_q + 32'(offset[i]),
                          gap:     gap_q && (offset[i] == '0)};
        end
    end

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        seq_d      = seq_q;
        drop_cnt_d = drop_cnt_q;
        gap_d      = gap_q;
        drop_sum   = {1'b0, drop_cnt_q} + 17'(count);
        if (accept) begin
            seq_d = seq_q + 32'(count);
        end
        if (push) begin
            wptr_d = wptr_q + AW'(count);
            gap_d  = 1'b0;
        end
        if (drop) begin
            drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            gap_d      = 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        level_d = level_q + (push ? LW'(count) : '0) - LW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            seq_q      <= '0;
            drop_cnt_q <= '0;
            gap_q      <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            seq_q      <= seq_d;
            drop_cnt_q <= drop_cnt_d;
            gap_q      <= gap_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (push && active[i]) begin
                mem[wr_idx[i]] <= wr_rec[i];
            end
        end
    end

    assign in_ready  = accept;
    assign out_valid = (level_q != '0);
    assign out_rec   = mem[rptr_q];
    assign level     = level_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
